// File: rtl/ex_mcycle_ctrl_pkg.sv
// Shared encodings for the EX multi-cycle sequencer:
// op kinds, FSM states, pass counts and stall vectors.
package ex_mcycle_ctrl_pkg;

  localparam logic [1:0] MC_MADD = 2'b01;
  localparam logic [1:0] MC_DIV  = 2'b10;

  typedef enum logic [2:0] {
    MC_IDLE     = 3'd0,
    MC_MADD_FIN = 3'd1,
    MC_DIV_WAIT = 3'd2,
    MC_DIV_RUN  = 3'd3,
    MC_DIV_FIN  = 3'd4
  } mc_state_t;

  localparam logic [1:0] CNT_IDLE  = 2'b00;
  localparam logic [1:0] CNT_FINAL = 2'b10;

  // {wb,mem,ex,id,if,pc}, 1 = stop
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

endpackage

// File: rtl/ex_mcycle_ctrl.sv
// Multi-cycle EX sequencer (madd/msub two-pass, div handshake)
// plus the pipeline stall vector.
// Ports:
//   clk, rst            clock / async active-high reset
//   stallreq_id/_mem    ID and MEM stall requests
//   flush_i             annul the in-flight EX op
//   ex_mc_req/_kind     EX multi-cycle op present / kind
//   ex_hilo_part        first-pass product from EX
//   div_ready_i         divider result valid pulse
//   stall               {wb,mem,ex,id,if,pc} stop bits
//   hilo_tmp_o, cnt_o   partial product and pass count to EX
//   div_start_o/_annul_o divider control pulses
//   mc_done_o           EX completes the op this cycle
//   div_err_o           divider timeout pulse
module ex_mcycle_ctrl
  import ex_mcycle_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = 40,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_mem,
  input  logic        flush_i,
  input  logic        ex_mc_req,
  input  logic [1:0]  ex_mc_kind,
  input  logic [63:0] ex_hilo_part,
  input  logic        div_ready_i,
  output logic [5:0]  stall,
  output logic [63:0] hilo_tmp_o,
  output logic [1:0]  cnt_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        mc_done_o,
  output logic        div_err_o
);

  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(DIV_TIMEOUT - 1);

  mc_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;

  logic w_busy;
  logic w_kind_ok;
  logic w_ex_stall;
  logic w_abort;
  logic w_issue;
  logic w_div_act;
  logic w_tmo;

  assign w_busy    = (r_state != MC_IDLE);
  assign w_kind_ok = (ex_mc_kind == MC_MADD) |
                     (ex_mc_kind == MC_DIV);
  // The err cycle ends the op like done does, so EX is
  // released and the same request cannot re-issue.
  assign w_ex_stall = ex_mc_req & ~mc_done_o &
                      ~div_err_o & ~flush_i &
                      (w_busy | w_kind_ok);
  // A request vanishing mid-op is handled as a flush.
  assign w_abort = w_busy & (flush_i | ~ex_mc_req);
  assign w_issue = ~w_busy & ex_mc_req &
                   ~flush_i & ~div_err_o;
  assign w_div_act = (r_state == MC_DIV_WAIT) |
                     (r_state == MC_DIV_RUN);
  assign w_tmo = (r_cnt == TMO_LAST);

  always_comb begin
    stall = STALL_NONE;
    if (rst)               stall = STALL_NONE;
    else if (stallreq_mem) stall = STALL_MEM;
    else if (w_ex_stall)   stall = STALL_EX;
    else if (stallreq_id)  stall = STALL_ID;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= MC_IDLE;
      r_cnt       <= '0;
      hilo_tmp_o  <= '0;
      cnt_o       <= CNT_IDLE;
      div_start_o <= 1'b0;
      div_annul_o <= 1'b0;
      mc_done_o   <= 1'b0;
      div_err_o   <= 1'b0;
    end else begin
      div_start_o <= 1'b0;
      div_annul_o <= 1'b0;
      div_err_o   <= 1'b0;
      if (w_abort) begin
        r_state     <= MC_IDLE;
        r_cnt       <= '0;
        hilo_tmp_o  <= '0;
        cnt_o       <= CNT_IDLE;
        mc_done_o   <= 1'b0;
        div_annul_o <= w_div_act;
      end else begin
        unique case (r_state)
          MC_IDLE: begin
            if (w_issue && ex_mc_kind == MC_MADD) begin
              hilo_tmp_o <= ex_hilo_part;
              cnt_o      <= CNT_FINAL;
              mc_done_o  <= 1'b1;
              r_state    <= MC_MADD_FIN;
            end else if (w_issue &&
                         ex_mc_kind == MC_DIV) begin
              div_start_o <= 1'b1;
              r_state     <= MC_DIV_WAIT;
            end
          end
          // Done is held while MEM stalls so EX
          // retires the op exactly once.
          MC_MADD_FIN: begin
            if (!stallreq_mem) begin
              r_state    <= MC_IDLE;
              cnt_o      <= CNT_IDLE;
              hilo_tmp_o <= '0;
              mc_done_o  <= 1'b0;
            end
          end
          MC_DIV_WAIT: begin
            r_state <= MC_DIV_RUN;
            r_cnt   <= '0;
          end
          MC_DIV_RUN: begin
            if (div_ready_i) begin
              r_state   <= MC_DIV_FIN;
              mc_done_o <= 1'b1;
            end else if (w_tmo) begin
              r_state     <= MC_IDLE;
              r_cnt       <= '0;
              div_err_o   <= 1'b1;
              div_annul_o <= 1'b1;
            end else if (r_cnt != '1) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          MC_DIV_FIN: begin
            if (!stallreq_mem) begin
              r_state   <= MC_IDLE;
              mc_done_o <= 1'b0;
            end
          end
          default: r_state <= MC_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_mcycle_ctrl.sv
// Directed bench for ex_mcycle_ctrl: reset, madd, div,
// timeout, flush, MEM-stall hold, unknown kind, back-to-back.
module tb_ex_mcycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id;
  logic        stallreq_mem;
  logic        flush_i;
  logic        ex_mc_req;
  logic [1:0]  ex_mc_kind;
  logic [63:0] ex_hilo_part;
  logic        div_ready_i;
  logic [5:0]  stall;
  logic [63:0] hilo_tmp_o;
  logic [1:0]  cnt_o;
  logic        div_start_o;
  logic        div_annul_o;
  logic        mc_done_o;
  logic        div_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_mcycle_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_mem (stallreq_mem),
    .flush_i      (flush_i),
    .ex_mc_req    (ex_mc_req),
    .ex_mc_kind   (ex_mc_kind),
    .ex_hilo_part (ex_hilo_part),
    .div_ready_i  (div_ready_i),
    .stall        (stall),
    .hilo_tmp_o   (hilo_tmp_o),
    .cnt_o        (cnt_o),
    .div_start_o  (div_start_o),
    .div_annul_o  (div_annul_o),
    .mc_done_o    (mc_done_o),
    .div_err_o    (div_err_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stallreq_id  = 1'b0;
    stallreq_mem = 1'b0;
    flush_i      = 1'b0;
    ex_mc_req    = 1'b0;
    ex_mc_kind   = 2'b00;
    ex_hilo_part = '0;
    div_ready_i  = 1'b0;
  endtask

  task automatic test_reset();
    logic [75:0] o;
    idle_inputs();
    rst = 1'b1;
    #2;
    o = {stall, hilo_tmp_o, cnt_o, div_start_o,
         div_annul_o, mc_done_o, div_err_o};
    n_tests++;
    if (o !== '0) begin
      n_fail++;
      $display("FAIL reset_outs got %h exp 0", o);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_madd();
    step();
    ex_mc_req = 1'b1;
    ex_mc_kind = 2'b01;
    ex_hilo_part = 64'h1_0000_0002;
    #1;
    n_tests++;
    if (stall !== 6'b001111) begin
      n_fail++;
      $display("FAIL madd_c0_stall got %b exp 001111", stall);
    end
    step();
    #1;
    n_tests++;
    if ({cnt_o, hilo_tmp_o, mc_done_o, stall} !==
        {2'b10, 64'h1_0000_0002, 1'b1, 6'b0}) begin
      n_fail++;
      $display("FAIL madd_c1 got cnt=%b hilo=%h done=%b stall=%b exp 10/100000002/1/000000",
               cnt_o, hilo_tmp_o, mc_done_o, stall);
    end
    step();
    ex_mc_req = 1'b0;
    #1;
    n_tests++;
    if ({cnt_o, hilo_tmp_o, mc_done_o} !== '0) begin
      n_fail++;
      $display("FAIL madd_c2 got cnt=%b hilo=%h done=%b exp 0",
               cnt_o, hilo_tmp_o, mc_done_o);
    end
  endtask

  task automatic test_div();
    int done_cyc = -1;
    int bad = 0;
    int starts = 0;
    step();
    ex_mc_req = 1'b1;
    ex_mc_kind = 2'b10;
    #1;
    n_tests++;
    if (stall !== 6'b001111) begin
      n_fail++;
      $display("FAIL div_c0_stall got %b exp 001111", stall);
    end
    for (int k = 1; k < 100; k++) begin
      step();
      // ready in the WAIT cycle must be ignored
      div_ready_i = (k == 1) || (k == 35);
      #1;
      if (div_start_o) starts += (k == 1) ? 1 : 10;
      if (mc_done_o) begin
        done_cyc = k;
        break;
      end
      if (stall !== 6'b001111) bad++;
    end
    n_tests++;
    if (starts !== 1) begin
      n_fail++;
      $display("FAIL div_start got code %0d exp 1", starts);
    end
    n_tests++;
    if (done_cyc !== 36) begin
      n_fail++;
      $display("FAIL div_done_cycle got %0d exp 36", done_cyc);
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL div_stall_hold got %0d bad exp 0", bad);
    end
    n_tests++;
    if (stall !== 6'b000000) begin
      n_fail++;
      $display("FAIL div_fin_stall got %b exp 000000", stall);
    end
    step();
    ex_mc_req = 1'b0;
    div_ready_i = 1'b0;
    #1;
    n_tests++;
    if (mc_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL div_done_width got %b exp 0", mc_done_o);
    end
  endtask

  task automatic test_timeout();
    int err_cyc = -1;
    step();
    ex_mc_req = 1'b1;
    ex_mc_kind = 2'b10;
    for (int k = 1; k < 80; k++) begin
      step();
      #1;
      if (div_err_o) begin
        err_cyc = k;
        break;
      end
    end
    n_tests++;
    if (err_cyc !== 42) begin
      n_fail++;
      $display("FAIL tmo_cycle got %0d exp 42", err_cyc);
    end
    n_tests++;
    if ({div_annul_o, mc_done_o, stall} !== {1'b1, 1'b0, 6'b0}) begin
      n_fail++;
      $display("FAIL tmo_outs got annul=%b done=%b stall=%b exp 1/0/000000",
               div_annul_o, mc_done_o, stall);
    end
    step();
    ex_mc_req = 1'b0;
    #1;
    n_tests++;
    if ({div_err_o, div_annul_o, div_start_o, stall} !== '0) begin
      n_fail++;
      $display("FAIL tmo_after got err=%b annul=%b start=%b stall=%b exp 0",
               div_err_o, div_annul_o, div_start_o, stall);
    end
  endtask

  task automatic test_flush_ready();
    step();
    ex_mc_req = 1'b1;
    ex_mc_kind = 2'b10;
    for (int k = 1; k <= 5; k++) step();
    flush_i = 1'b1;
    div_ready_i = 1'b1;
    #1;
    n_tests++;
    if (stall !== 6'b000000) begin
      n_fail++;
      $display("FAIL flush_stall got %b exp 000000", stall);
    end
    step();
    flush_i = 1'b0;
    div_ready_i = 1'b0;
    ex_mc_req = 1'b0;
    #1;
    n_tests++;
    if ({div_annul_o, mc_done_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_annul got annul=%b done=%b exp 1/0",
               div_annul_o, mc_done_o);
    end
    step();
    n_tests++;
    if ({div_annul_o, mc_done_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_after got annul=%b done=%b exp 0/0",
               div_annul_o, mc_done_o);
    end
  endtask

  task automatic test_mem_madd();
    step();
    stallreq_mem = 1'b1;
    stallreq_id = 1'b1;
    ex_mc_req = 1'b1;
    ex_mc_kind = 2'b01;
    ex_hilo_part = 64'hDEAD_BEEF_0000_0005;
    #1;
    n_tests++;
    if (stall !== 6'b011111) begin
      n_fail++;
      $display("FAIL mem_c0_stall got %b exp 011111", stall);
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      n_tests++;
      if ({mc_done_o, cnt_o, stall} !== {1'b1, 2'b10, 6'b011111}) begin
        n_fail++;
        $display("FAIL mem_hold%0d got done=%b cnt=%b stall=%b exp 1/10/011111",
                 k, mc_done_o, cnt_o, stall);
      end
    end
    step();
    stallreq_mem = 1'b0;
    stallreq_id = 1'b0;
    #1;
    n_tests++;
    if ({mc_done_o, hilo_tmp_o, stall} !==
        {1'b1, 64'hDEAD_BEEF_0000_0005, 6'b0}) begin
      n_fail++;
      $display("FAIL mem_release got done=%b hilo=%h stall=%b exp 1/deadbeef00000005/000000",
               mc_done_o, hilo_tmp_o, stall);
    end
    step();
    ex_mc_req = 1'b0;
    #1;
    n_tests++;
    if ({mc_done_o, cnt_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL mem_end got done=%b cnt=%b exp 0/00",
               mc_done_o, cnt_o);
    end
  endtask

  task automatic test_unknown_kind();
    step();
    ex_mc_req = 1'b1;
    ex_mc_kind = 2'b11;
    stallreq_id = 1'b1;
    #1;
    n_tests++;
    if (stall !== 6'b000111) begin
      n_fail++;
      $display("FAIL unk_stall got %b exp 000111", stall);
    end
    step();
    n_tests++;
    if ({mc_done_o, div_start_o, cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL unk_state got done=%b start=%b cnt=%b exp 0",
               mc_done_o, div_start_o, cnt_o);
    end
    ex_mc_req = 1'b0;
    stallreq_id = 1'b0;
  endtask

  task automatic test_back_to_back();
    step();
    ex_mc_req = 1'b1;
    ex_mc_kind = 2'b01;
    ex_hilo_part = 64'h0000_0000_0000_00AA;
    step();
    ex_hilo_part = 64'h0000_0000_0000_00BB;
    step();
    #1;
    n_tests++;
    if ({mc_done_o, cnt_o, stall} !== {1'b0, 2'b00, 6'b001111}) begin
      n_fail++;
      $display("FAIL b2b_gap got done=%b cnt=%b stall=%b exp 0/00/001111",
               mc_done_o, cnt_o, stall);
    end
    step();
    n_tests++;
    if ({mc_done_o, hilo_tmp_o} !== {1'b1, 64'hBB}) begin
      n_fail++;
      $display("FAIL b2b_second got done=%b hilo=%h exp 1/bb",
               mc_done_o, hilo_tmp_o);
    end
    ex_mc_req = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    logic [75:0] o;
    step();
    ex_mc_req = 1'b1;
    ex_mc_kind = 2'b10;
    for (int k = 1; k <= 6; k++) step();
    #2;
    rst = 1'b1;
    #1;
    o = {stall, hilo_tmp_o, cnt_o, div_start_o,
         div_annul_o, mc_done_o, div_err_o};
    n_tests++;
    if (o !== '0) begin
      n_fail++;
      $display("FAIL async_rst got %h exp 0", o);
    end
    step();
    rst = 1'b0;
    ex_mc_kind = 2'b01;
    ex_hilo_part = 64'h77;
    step();
    n_tests++;
    if ({mc_done_o, hilo_tmp_o} !== {1'b1, 64'h77}) begin
      n_fail++;
      $display("FAIL async_rst_idle got done=%b hilo=%h exp 1/77",
               mc_done_o, hilo_tmp_o);
    end
    ex_mc_req = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_madd();
    test_div();
    test_timeout();
    test_flush_ready();
    test_mem_madd();
    test_unknown_kind();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
